// File: rtl/pixel_mem_pkg.sv
// Shared types and default sizes for the pixel memory responder.
package pixel_mem_pkg;

    localparam int unsigned REQ_ADDR_W    = 24;
    localparam int unsigned DEF_DATA_BITS = 16;
    localparam int unsigned DEF_ADDR_BITS = 15;
    localparam int unsigned LAT_W         = 4;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        ACK
    } state_t;

    typedef enum logic {
        GRANT_READ,
        GRANT_WRITE
    } grant_t;

endpackage

// File: rtl/word_store.sv
// Single-port synchronous word store, write-first, output register updates only on read strobe.
module word_store #(
    parameter int unsigned ADDR_BITS = 15,
    parameter int unsigned DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] q
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0] mem [DEPTH];

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Output register holds the last read word between read strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (re) begin
            q <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/pixel_mem_responder.sv
// Memory-side responder for the frame-update read/write request/ack interface (BRAM stand-in for DDR).
// Optional RESP_STATS_EN adds readCount/writeCount ack counters.
module pixel_mem_responder
    import pixel_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = DEF_ADDR_BITS,
    parameter int unsigned DATA_BITS     = DEF_DATA_BITS,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic [REQ_ADDR_W-1:0] readAddress,
    output logic                  readAcknowledge,
    output logic [DATA_BITS-1:0]  readData,
    input  logic                  write,
    input  logic [REQ_ADDR_W-1:0] writeAddress,
    input  logic [DATA_BITS-1:0]  writeData,
    output logic                  writeAcknowledge
`ifdef RESP_STATS_EN
    ,
    output logic [15:0]           readCount,
    output logic [15:0]           writeCount
`endif
);

    state_t               state;
    grant_t               last_grant;
    logic                 read_armed;
    logic                 write_armed;
    logic [LAT_W-1:0]     lat_cnt;
    logic [ADDR_BITS-1:0] addr_q;

    logic                 pend_r;
    logic                 pend_w;
    logic                 grant_rd;
    logic                 grant_wr;
    logic                 rd_to_ack;
    logic                 wr_to_ack;
    logic                 store_we;
    logic                 store_re;
    logic [ADDR_BITS-1:0] store_addr;

    // Address bits above the decoded range alias onto the same word.
    logic                 unused_addr_bits;
    assign unused_addr_bits = ^{readAddress[REQ_ADDR_W-1:ADDR_BITS],
                                writeAddress[REQ_ADDR_W-1:ADDR_BITS]};

    // Arbitration and the cycle in which each operation reaches its ack.
    always_comb begin
        pend_r     = read & read_armed;
        pend_w     = write & write_armed;
        grant_rd   = 1'b0;
        grant_wr   = 1'b0;
        rd_to_ack  = 1'b0;
        wr_to_ack  = 1'b0;
        store_addr = addr_q;

        if (state == IDLE) begin
            grant_rd = pend_r && (!pend_w || last_grant == GRANT_WRITE);
            grant_wr = pend_w && !grant_rd;
        end

        rd_to_ack = (grant_rd && READ_LATENCY <= 1) ||
                    (state == RD_WAIT && lat_cnt == '0);
        wr_to_ack = (grant_wr && WRITE_LATENCY <= 1) ||
                    (state == WR_WAIT && lat_cnt == '0);

        if (grant_wr) begin
            store_addr = writeAddress[ADDR_BITS-1:0];
        end else if (state == IDLE) begin
            store_addr = readAddress[ADDR_BITS-1:0];
        end

        // Writes commit at the grant edge; reads land in the store's output register with the ack.
        store_we = grant_wr;
        store_re = rd_to_ack;
    end

    word_store #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_word_store (
        .clk   (clk),
        .rst   (rst),
        .we    (store_we),
        .re    (store_re),
        .addr  (store_addr),
        .wdata (writeData),
        .q     (readData)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            last_grant       <= GRANT_WRITE;
            read_armed       <= 1'b1;
            write_armed      <= 1'b1;
            lat_cnt          <= '0;
            addr_q           <= '0;
            readAcknowledge  <= 1'b0;
            writeAcknowledge <= 1'b0;
        end else begin
            readAcknowledge  <= rd_to_ack;
            writeAcknowledge <= wr_to_ack;

            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        addr_q     <= readAddress[ADDR_BITS-1:0];
                        last_grant <= GRANT_READ;
                        lat_cnt    <= LAT_W'(READ_LATENCY - 2);
                        state      <= (READ_LATENCY <= 1) ? ACK : RD_WAIT;
                    end else if (grant_wr) begin
                        addr_q     <= writeAddress[ADDR_BITS-1:0];
                        last_grant <= GRANT_WRITE;
                        lat_cnt    <= LAT_W'(WRITE_LATENCY - 2);
                        state      <= (WRITE_LATENCY <= 1) ? ACK : WR_WAIT;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= ACK;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A low request line always re-arms; a completed ack disarms a still-high line.
            if (!read) begin
                read_armed <= 1'b1;
            end else if (state == ACK && readAcknowledge) begin
                read_armed <= 1'b0;
            end

            if (!write) begin
                write_armed <= 1'b1;
            end else if (state == ACK && writeAcknowledge) begin
                write_armed <= 1'b0;
            end
        end
    end

`ifdef RESP_STATS_EN
    // Ack counters, visible in the same cycle as the ack they count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readCount  <= '0;
            writeCount <= '0;
        end else begin
            if (rd_to_ack) begin
                readCount <= readCount + 16'd1;
            end
            if (wr_to_ack) begin
                writeCount <= writeCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pixel_mem_responder.sv
// Directed self-checking bench for pixel_mem_responder (default latencies 2/1).
module tb_pixel_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        read;
    logic [23:0] readAddress;
    logic        readAcknowledge;
    logic [15:0] readData;
    logic        write;
    logic [23:0] writeAddress;
    logic [15:0] writeData;
    logic        writeAcknowledge;
`ifdef RESP_STATS_EN
    logic [15:0] readCount;
    logic [15:0] writeCount;
`endif

    int n_pass  = 0;
    int n_total = 0;

    pixel_mem_responder dut (
        .clk              (clk),
        .rst              (rst),
        .read             (read),
        .readAddress      (readAddress),
        .readAcknowledge  (readAcknowledge),
        .readData         (readData),
        .write            (write),
        .writeAddress     (writeAddress),
        .writeData        (writeData),
        .writeAcknowledge (writeAcknowledge)
`ifdef RESP_STATS_EN
        ,
        .readCount        (readCount),
        .writeCount       (writeCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Raise the requested lines in an idle cycle; record the cycle (1 = first edge after grant cycle) of each ack.
    task automatic xfer(input logic do_rd, input logic do_wr,
                        input logic [23:0] ra, input logic [23:0] wa, input logic [15:0] wd,
                        output int rc, output int wc, output logic [15:0] rv, output logic both);
        rc = -1; wc = -1; rv = 16'hxxxx; both = 1'b0;
        @(posedge clk); #1;
        read = do_rd; readAddress = ra;
        write = do_wr; writeAddress = wa; writeData = wd;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (readAcknowledge && writeAcknowledge) both = 1'b1;
            if (readAcknowledge) begin rc = n; rv = readData; read = 1'b0; end
            if (writeAcknowledge) begin wc = n; write = 1'b0; end
            if ((!do_rd || rc >= 0) && (!do_wr || wc >= 0)) break;
        end
        read = 1'b0; write = 1'b0;
    endtask

    task automatic pulse_rst();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int         rc, wc, cnt;
        logic [15:0] rv;
        logic        both;

        rst = 1'b1; read = 1'b0; write = 1'b0;
        readAddress = '0; writeAddress = '0; writeData = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rack", 32'(readAcknowledge), 32'd0);
        chk("rst_wack", 32'(writeAcknowledge), 32'd0);
        chk("rst_rdata", 32'(readData), 32'd0);
        rst = 1'b0;

        // Basic write then read with latency checks
        xfer(1'b0, 1'b1, 24'h0, 24'h000123, 16'hA5C3, rc, wc, rv, both);
        chk("wr_lat", 32'(wc), 32'd1);
        chk("wr_no_rack", 32'(rc), 32'hFFFF_FFFF);
        xfer(1'b1, 1'b0, 24'h000123, 24'h0, 16'h0, rc, wc, rv, both);
        chk("rd_lat", 32'(rc), 32'd2);
        chk("rd_data", 32'(rv), 32'hA5C3);

        // Contention right after reset: read wins, then the write
        xfer(1'b0, 1'b1, 24'h0, 24'h000010, 16'h0F0F, rc, wc, rv, both);
        pulse_rst();
        xfer(1'b1, 1'b1, 24'h000010, 24'h000010, 16'h1111, rc, wc, rv, both);
        chk("cont1_rd_lat", 32'(rc), 32'd2);
        chk("cont1_rd_data", 32'(rv), 32'h0F0F);
        chk("cont1_wr_lat", 32'(wc), 32'd4);
        chk("cont1_no_both", 32'(both), 32'd0);
        xfer(1'b1, 1'b0, 24'h000010, 24'h0, 16'h0, rc, wc, rv, both);
        chk("order_rd_data", 32'(rv), 32'h1111);
        // Last grant was a read, so the next contended pair goes to the write
        xfer(1'b1, 1'b1, 24'h000123, 24'h000020, 16'h2222, rc, wc, rv, both);
        chk("cont2_wr_lat", 32'(wc), 32'd1);
        chk("cont2_rd_lat", 32'(rc), 32'd4);
        chk("cont2_rd_data", 32'(rv), 32'hA5C3);
        chk("cont2_no_both", 32'(both), 32'd0);

        // Read held high long after its ack is serviced once
        @(posedge clk); #1;
        read = 1'b1; readAddress = 24'h000020;
        cnt = 0;
        repeat (22) begin @(posedge clk); #1; if (readAcknowledge) cnt++; end
        chk("held_acks", 32'(cnt), 32'd1);
        chk("held_data", 32'(readData), 32'h2222);
        read = 1'b0;
        @(posedge clk); #1;
        read = 1'b1;
        cnt = 0;
        repeat (5) begin @(posedge clk); #1; if (readAcknowledge) cnt++; end
        chk("rearm_acks", 32'(cnt), 32'd1);
        read = 1'b0;

        // Upper address bits are ignored
        xfer(1'b0, 1'b1, 24'h0, 24'h800010, 16'hBEEF, rc, wc, rv, both);
        chk("alias_wr_lat", 32'(wc), 32'd1);
        xfer(1'b1, 1'b0, 24'h000010, 24'h0, 16'h0, rc, wc, rv, both);
        chk("alias_rd_data", 32'(rv), 32'hBEEF);
        xfer(1'b0, 1'b1, 24'h0, 24'h007FFF, 16'h1234, rc, wc, rv, both);
        xfer(1'b1, 1'b0, 24'hFFFFFF, 24'h0, 16'h0, rc, wc, rv, both);
        chk("alias_top_data", 32'(rv), 32'h1234);

        // Reset while the read is waiting: no ack, data cleared
        @(posedge clk); #1;
        read = 1'b1; readAddress = 24'h000010;
        @(posedge clk); #1;
        chk("abort_pre_rack", 32'(readAcknowledge), 32'd0);
        rst = 1'b1; read = 1'b0;
        #1;
        chk("abort_rdata", 32'(readData), 32'd0);
        chk("abort_wack", 32'(writeAcknowledge), 32'd0);
        cnt = 0;
        repeat (3) begin @(posedge clk); #1; if (readAcknowledge || writeAcknowledge) cnt++; end
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (readAcknowledge || writeAcknowledge) cnt++; end
        chk("abort_no_ack", 32'(cnt), 32'd0);
        xfer(1'b1, 1'b0, 24'h000010, 24'h0, 16'h0, rc, wc, rv, both);
        chk("post_abort_lat", 32'(rc), 32'd2);
        chk("post_abort_data", 32'(rv), 32'hBEEF);

`ifdef RESP_STATS_EN
        pulse_rst();
        chk("stats_rst_r", 32'(readCount), 32'd0);
        chk("stats_rst_w", 32'(writeCount), 32'd0);
        for (int i = 0; i < 3; i++) xfer(1'b0, 1'b1, 24'h0, 24'(i), 16'(i), rc, wc, rv, both);
        for (int i = 0; i < 5; i++) xfer(1'b1, 1'b0, 24'(i), 24'h0, 16'h0, rc, wc, rv, both);
        @(posedge clk); #1;
        chk("stats_w", 32'(writeCount), 32'd3);
        chk("stats_r", 32'(readCount), 32'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
